cpu_reg_bank: RTL

Parametrised CPU-side control register bank and successor to the fixed-map write decoder. It adds the following over that decoder:
- configurable register count, width and base address
- 1-cycle registered read-back
- per-register self-clearing pulse mode with programmable hold length
- per-register write strobes
- a sticky address-error register with write-1-to-clear

It sits between the NIOS bus and the MAC/SDRAM/channel control logic.

---
 rtl/cpu_reg_pkg.sv | 31 +++
 rtl/cpu_reg_bank_pulse_timer.sv | 30 +++
 rtl/cpu_reg_bank.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cpu_reg_pkg.sv
// Shared types and helpers for the CPU control register bank.
// Covers address-to-index decoding and counter sizing.
package cpu_reg_pkg;

   localparam int ERR_BIT = 0;
   localparam int IDX_W   = 6;

   typedef struct packed {
      logic             in_range;
      logic [IDX_W-1:0] idx;
   } reg_sel_t;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return (w == 0) ? 1 : w;
   endfunction

   // The difference is taken one bit wider, so an address below base shows up as negative.
   function automatic reg_sel_t reg_idx(input logic [31:0] addr, input logic [31:0] base,
                                        input int num_regs);
      logic [32:0] diff;
      reg_sel_t    sel;
      diff         = {1'b0, addr} - {1'b0, base};
      sel.in_range = !diff[32] && (diff < 33'(num_regs));
      sel.idx      = diff[IDX_W-1:0];
      return sel;
   endfunction

endpackage

// File: rtl/cpu_reg_bank_pulse_timer.sv
// Down-counter for one self-clearing register.
// expire is high during the cycle whose closing edge takes the count from 1 to 0.
module pulse_timer
   import cpu_reg_pkg::*;
#(
   parameter int LEN = 4
) (
   input  logic clk,
   input  logic pRST,
   input  logic load,
   output logic expire
);

   localparam int CNT_W = clog2(LEN + 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (pRST) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= CNT_W'(LEN);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign expire = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/cpu_reg_bank.sv
// Parametrised CPU-side control register bank with registered read-back,
// per-register write strobes, self-clearing pulse registers and a sticky address-error flag.
module cpu_reg_bank
   import cpu_reg_pkg::*;
#(
   parameter int                         ADDR_W     = 9,
   parameter int                         DATA_W     = 32,
   parameter int                         NUM_REGS   = 16,
   parameter int                         BASE_ADDR  = 1,
   parameter logic [NUM_REGS-1:0]        PULSE_MASK = '0,
   parameter int                         PULSE_LEN  = 4,
   parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL    = '0
) (
   input  logic                         clk,
   input  logic                         pRST,
   input  logic                         cpu_wr_n,
   input  logic                         cpu_rd_n,
   input  logic [ADDR_W-1:0]            cpu_addr,
   input  logic [DATA_W-1:0]            cpu_wdata,
   output logic [DATA_W-1:0]            cpu_rdata,
   output logic                         cpu_rvalid,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q,
   output logic [NUM_REGS-1:0]          reg_wstb,
   output logic                         error
);

   localparam int          MAX_REGS = 1 << IDX_W;
   localparam logic [32:0] ERR_ADDR = 33'(BASE_ADDR) + 33'(NUM_REGS);

   reg_sel_t          w_sel;
   logic              w_wr;
   logic              w_rd;
   logic              w_is_err_addr;
   logic              w_bad_addr;
   logic [DATA_W-1:0] w_err_word;
   logic [DATA_W-1:0] w_rd_value;
   logic [DATA_W-1:0] w_regs [MAX_REGS];

   logic [DATA_W-1:0] r_rdata;
   logic              r_rvalid;
   logic              r_error;

   assign w_sel         = reg_idx(32'(cpu_addr), 32'(BASE_ADDR), NUM_REGS);
   assign w_wr          = !cpu_wr_n;
   assign w_rd          = !cpu_rd_n;
   assign w_is_err_addr = (33'(cpu_addr) == ERR_ADDR);
   assign w_bad_addr    = !w_sel.in_range && !w_is_err_addr;

   genvar gi;
   generate
      for (gi = 0; gi < MAX_REGS; gi++) begin : g_reg
         if (gi < NUM_REGS) begin : g_used
            logic              w_load;
            logic              w_expire;
            logic [DATA_W-1:0] r_reg;
            logic              r_wstb;

            assign w_load = w_wr && w_sel.in_range && (w_sel.idx == IDX_W'(gi));

            if (PULSE_MASK[gi]) begin : g_pulse
               pulse_timer #(.LEN(PULSE_LEN)) u_timer (
                  .clk    (clk),
                  .pRST   (pRST),
                  .load   (w_load),
                  .expire (w_expire)
               );
            end else begin : g_static
               assign w_expire = 1'b0;
            end

            // A write on the expiry edge wins, so a rewrite never leaves a gap.
            always_ff @(posedge clk) begin
               if (pRST) begin
                  r_reg  <= RST_VAL[gi*DATA_W +: DATA_W];
                  r_wstb <= 1'b0;
               end else begin
                  r_wstb <= w_load;
                  if (w_load) begin
                     r_reg <= cpu_wdata;
                  end else if (w_expire) begin
                     r_reg <= RST_VAL[gi*DATA_W +: DATA_W];
                  end
               end
            end

            assign w_regs[gi]                  = r_reg;
            assign reg_q[gi*DATA_W +: DATA_W]  = r_reg;
            assign reg_wstb[gi]                = r_wstb;
         end else begin : g_unused
            assign w_regs[gi] = '0;
         end
      end
   endgenerate

   always_comb begin
      w_err_word          = '0;
      w_err_word[ERR_BIT] = r_error;
      w_rd_value          = '0;
      if (w_sel.in_range) begin
         w_rd_value = w_regs[w_sel.idx];
      end else if (w_is_err_addr) begin
         w_rd_value = w_err_word;
      end
   end

   always_ff @(posedge clk) begin
      if (pRST) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         r_rvalid <= w_rd;
         if (w_rd) begin
            r_rdata <= w_rd_value;
         end
         if ((w_wr || w_rd) && w_bad_addr) begin
            r_error <= 1'b1;
         end else if (w_wr && w_is_err_addr && cpu_wdata[ERR_BIT]) begin
            r_error <= 1'b0;
         end
      end
   end

   assign cpu_rdata  = r_rdata;
   assign cpu_rvalid = r_rvalid;
   assign error      = r_error;

endmodule
